// File: rtl/cacheline_burst_adaptor_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package : cacheline_pkg                                                  |
// | Purpose : Shared types and elaboration helpers for the cache-line burst  |
// |           adaptor: burst FSM state encoding, beat count, byte-offset     |
// |           width and beat-index width derived from the line/bus widths.   |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
package cacheline_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_BURST = 2'd1,
    WR_BURST = 2'd2,
    DONE     = 2'd3
  } burst_state_e;

  // Number of bus beats that make up one cache line.
  function automatic int beats_f(input int line_w, input int bus_w);
    return line_w / bus_w;
  endfunction

  // Width of the byte offset inside one cache line.
  function automatic int off_w_f(input int line_w);
    return $clog2(line_w / 8);
  endfunction

  // Width of the beat counter; kept at least 1 so a degenerate
  // configuration still elaborates far enough to report its error.
  function automatic int beat_idx_w_f(input int line_w, input int bus_w);
    return (beats_f(line_w, bus_w) > 1) ? $clog2(beats_f(line_w, bus_w)) : 1;
  endfunction

endpackage : cacheline_pkg
`default_nettype wire

// File: rtl/cacheline_burst_adaptor_line_beat_buffer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : line_beat_buffer                                               |
// | Purpose : One cache-line register that is loaded either as a whole line  |
// |           or one bus-wide beat at a time, and read back either as a      |
// |           whole line or as the beat selected by beat_idx.                |
// | Ports   : clk, rst        - clock, synchronous active-high reset         |
// |           load_line       - capture line_in into the register            |
// |           line_in         - full line to capture                         |
// |           load_beat       - capture beat_in into slice beat_idx          |
// |           beat_idx        - beat slice selected for load and readout     |
// |           beat_in         - beat to capture                              |
// |           beat_out        - slice beat_idx of the register               |
// |           line_out        - whole register                               |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module line_beat_buffer
  import cacheline_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int BUS_W  = 64,
  parameter int IDX_W  = beat_idx_w_f(LINE_W, BUS_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_line,
  input  logic [LINE_W-1:0] line_in,
  input  logic              load_beat,
  input  logic [IDX_W-1:0]  beat_idx,
  input  logic [BUS_W-1:0]  beat_in,
  output logic [BUS_W-1:0]  beat_out,
  output logic [LINE_W-1:0] line_out
);

  localparam int BEATS = beats_f(LINE_W, BUS_W);

  logic [LINE_W-1:0] line_q;
  logic [LINE_W-1:0] line_d;

  // A whole-line load takes priority over a beat load.
  always_comb begin
    line_d = line_q;
    if (load_line) begin
      line_d = line_in;
    end else if (load_beat) begin
      for (int i = 0; i < BEATS; i++) begin
        if (beat_idx == IDX_W'(i)) begin
          line_d[i*BUS_W +: BUS_W] = beat_in;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  always_comb begin
    beat_out = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (beat_idx == IDX_W'(i)) begin
        beat_out = line_q[i*BUS_W +: BUS_W];
      end
    end
  end

  assign line_out = line_q;

endmodule : line_beat_buffer
`default_nettype wire

// File: rtl/cacheline_burst_adaptor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : cacheline_burst_adaptor                                        |
// | Purpose : Bridges a cache controller's full-line port to a narrow burst  |
// |           memory port. A line read is assembled from BEATS bus beats and |
// |           a line write is split into BEATS beats, lowest word first, at  |
// |           a line-aligned burst address.                                  |
// | Ports   : clk, rst                   - clock, sync active-high reset     |
// |           ca_address/ca_read/ca_write/ca_wdata - cache-side request      |
// |           ca_rdata/ca_resp           - assembled line, completion pulse  |
// |           pm_address/pm_read/pm_write/pm_wdata - memory burst request    |
// |           pm_rdata/pm_resp           - memory beat data, beat handshake  |
// | Rev     : 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module cacheline_burst_adaptor
  import cacheline_pkg::*;
#(
  parameter int LINE_W = 256,
  parameter int BUS_W  = 64,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] ca_address,
  input  logic              ca_read,
  input  logic              ca_write,
  input  logic [LINE_W-1:0] ca_wdata,
  output logic [LINE_W-1:0] ca_rdata,
  output logic              ca_resp,
  output logic [ADDR_W-1:0] pm_address,
  output logic              pm_read,
  output logic              pm_write,
  output logic [BUS_W-1:0]  pm_wdata,
  input  logic [BUS_W-1:0]  pm_rdata,
  input  logic              pm_resp
);

  localparam int BEATS  = beats_f(LINE_W, BUS_W);
  localparam int OFF_W  = off_w_f(LINE_W);
  localparam int BEAT_W = beat_idx_w_f(LINE_W, BUS_W);
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  if ((LINE_W % BUS_W) != 0 || BEATS < 2) begin : g_bad_params
    $error("cacheline_burst_adaptor: LINE_W must be a multiple of BUS_W with at least 2 beats");
  end

  burst_state_e      state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [ADDR_W-1:0] pm_address_q, pm_address_d;

  logic              load_line;
  logic              load_beat;
  logic [BUS_W-1:0]  beat_data;

  // The byte offset within the line never reaches the memory port.
  logic unused_offset_bits;
  assign unused_offset_bits = ^ca_address[OFF_W-1:0];

  line_beat_buffer #(
    .LINE_W (LINE_W),
    .BUS_W  (BUS_W)
  ) u_buffer (
    .clk       (clk),
    .rst       (rst),
    .load_line (load_line),
    .line_in   (ca_wdata),
    .load_beat (load_beat),
    .beat_idx  (beat_q),
    .beat_in   (pm_rdata),
    .beat_out  (beat_data),
    .line_out  (ca_rdata)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      pm_address_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_q       <= beat_d;
      pm_address_q <= pm_address_d;
    end
  end

  // Next-state logic. pm_resp only matters inside a burst; the request
  // lines only matter in IDLE, so a request still held during DONE
  // cannot start a second burst.
  always_comb begin
    state_d      = state_q;
    beat_d       = beat_q;
    pm_address_d = pm_address_q;
    load_line    = 1'b0;
    load_beat    = 1'b0;
    case (state_q)
      IDLE: begin
        if (ca_write || ca_read) begin
          state_d      = ca_write ? WR_BURST : RD_BURST;
          pm_address_d = {ca_address[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
          beat_d       = '0;
          load_line    = 1'b1;
        end
      end
      RD_BURST, WR_BURST: begin
        if (pm_resp) begin
          load_beat = (state_q == RD_BURST);
          if (beat_q == LAST_BEAT) begin
            beat_d  = '0;
            state_d = DONE;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase
  end

  // Outputs, decoded from the current state only.
  always_comb begin
    ca_resp  = (state_q == DONE);
    pm_read  = (state_q == RD_BURST);
    pm_write = (state_q == WR_BURST);
    pm_wdata = (state_q == WR_BURST) ? beat_data : '0;
  end

  assign pm_address = pm_address_q;

endmodule : cacheline_burst_adaptor
`default_nettype wire
